// File: rtl/lcd_frame_ctrl.sv
// rtl/lcd_frame_ctrl.sv - HD44780 16x2 frame controller: init sequence, BCD value render, update handshake
module lcd_frame_ctrl #(
   parameter int VALUE_W        = 16,
   parameter int DIGITS         = 5,
   parameter int SIGNED_MODE    = 1,
   parameter int STEP_CYCLES    = 5000,
   parameter int CLEAR_CYCLES   = 10000,
   parameter int POWERUP_CYCLES = 75000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               upd_valid,
   output logic               upd_ready,
   input  logic [VALUE_W-1:0] value,
   input  logic [2:0]         opcode,
   input  logic [2:0]         estado,
   output logic               busy,
   output logic               lcd_en,
   output logic               lcd_rs,
   output logic               lcd_rw,
   output logic [7:0]         lcd_data
);

   localparam int BCD_W   = 4 * DIGITS;
   localparam int WR_TOT  = 2 * STEP_CYCLES + CLEAR_CYCLES;
   localparam int M1      = (POWERUP_CYCLES > WR_TOT) ? POWERUP_CYCLES : WR_TOT;
   localparam int CNT_MAX = (M1 > VALUE_W) ? M1 : VALUE_W;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] EN_OFF   = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_END   = CNT_W'(2 * STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLR_END  = CNT_W'(WR_TOT - 1);
   localparam logic [CNT_W-1:0] PWR_END  = CNT_W'(POWERUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CONV_END = CNT_W'(VALUE_W - 1);
   localparam logic [5:0]       LAST_WR  = 6'd33;

   typedef enum logic [2:0] {
      S_PWRUP,
      S_INIT,
      S_CONVERT,
      S_FRAME,
      S_IDLE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [5:0]         idx_q, idx_d;
   logic               en_q, en_d;
   logic               rs_q, rs_d;
   logic [7:0]         data_q, data_d;
   logic [2:0]         opc_q, opc_d;
   logic               est_nz_q, est_nz_d;
   logic               neg_q, neg_d;
   logic [VALUE_W-1:0] shift_q, shift_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;

   logic [BCD_W-1:0]   adj;
   logic [8:0]         nxt_w;
   logic               load_neg;
   logic [VALUE_W-1:0] load_mag;

   // Power-on command list: function set 8-bit/2-line, display on, clear, entry mode
   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      logic [7:0] c;
      case (i)
         2'd0:    c = 8'h38;
         2'd1:    c = 8'h0E;
         2'd2:    c = 8'h01;
         default: c = 8'h06;
      endcase
      return c;
   endfunction

   function automatic logic [7:0] mnem_char(input logic [2:0] op, input logic [1:0] p);
      logic [31:0] s;
      logic [7:0]  c;
      case (op)
         3'd0:    s = "LOAD";
         3'd1:    s = "ADD ";
         3'd2:    s = "ADDI";
         3'd3:    s = "SUB ";
         3'd4:    s = "SUBI";
         3'd5:    s = "MUL ";
         3'd6:    s = "CLR ";
         default: s = "DPL ";
      endcase
      case (p)
         2'd0:    c = s[31:24];
         2'd1:    c = s[23:16];
         2'd2:    c = s[15:8];
         default: c = s[7:0];
      endcase
      return c;
   endfunction

   // {rs, data} of frame write i: 0 = line-1 address, 1..16 line 1, 17 = line-2 address, 18..33 line 2
   function automatic logic [8:0] char_at(input logic [5:0] i);
      int         pos;
      int         k;
      logic [1:0] b;
      logic [3:0] dig;
      logic [7:0] ch;
      ch  = 8'h20;
      pos = 0;
      k   = 0;
      b   = 2'd0;
      dig = 4'd0;
      if (i == 6'd0) return {1'b0, 8'h80};
      if (i == 6'd17) return {1'b0, 8'hC0};
      if (i <= 6'd16) begin
         pos = int'(i) - 1;
         if (pos < 4) begin
            ch = est_nz_q ? mnem_char(opc_q, pos[1:0]) : "-";
         end else if (pos == 11) begin
            ch = "[";
         end else if (pos == 15) begin
            ch = "]";
         end else if (pos >= 12) begin
            b  = 2'(14 - pos);
            ch = !est_nz_q ? "-" : (opc_q[b] ? "1" : "0");
         end
      end else begin
         pos = int'(i) - 18;
         if (pos == 15 - DIGITS) begin
            if (SIGNED_MODE == 0) ch = 8'h20;
            else                  ch = (neg_q && est_nz_q) ? "-" : "+";
         end else if (pos > 15 - DIGITS) begin
            k   = pos - (16 - DIGITS);
            dig = bcd_q[4*(DIGITS-1-k) +: 4];
            ch  = 8'h30 + {4'h0, dig};
         end
      end
      return {1'b1, ch};
   endfunction

   // Magnitude and sign captured at accept; the most negative value negates to itself as unsigned
   assign load_neg = (SIGNED_MODE != 0) && value[VALUE_W-1];
   assign load_mag = load_neg ? (~value + VALUE_W'(1)) : value;

   // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift
   always_comb begin
      adj = bcd_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
   end

   // Sequencer: next state, write timing, bus contents and conversion datapath
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      en_d     = en_q;
      rs_d     = rs_q;
      data_d   = data_q;
      opc_d    = opc_q;
      est_nz_d = est_nz_q;
      neg_d    = neg_q;
      shift_d  = shift_q;
      bcd_d    = bcd_q;
      nxt_w    = char_at(idx_q + 6'd1);
      case (state_q)
         S_PWRUP: begin
            if (cnt_q == PWR_END) begin
               state_d = S_INIT;
               cnt_d   = '0;
               idx_d   = '0;
               en_d    = 1'b1;
               rs_d    = 1'b0;
               data_d  = init_cmd(2'd0);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_INIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == EN_OFF) en_d = 1'b0;
            if (cnt_q == ((idx_q == 6'd2) ? CLR_END : WR_END)) begin
               cnt_d = '0;
               if (idx_q == 6'd3) begin
                  state_d  = S_CONVERT;
                  opc_d    = '0;
                  est_nz_d = 1'b0;
                  neg_d    = 1'b0;
                  shift_d  = '0;
                  bcd_d    = '0;
               end else begin
                  idx_d  = idx_q + 6'd1;
                  en_d   = 1'b1;
                  rs_d   = 1'b0;
                  data_d = init_cmd(idx_q[1:0] + 2'd1);
               end
            end
         end
         S_CONVERT: begin
            bcd_d   = {adj[BCD_W-2:0], shift_q[VALUE_W-1]};
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CONV_END) begin
               state_d = S_FRAME;
               cnt_d   = '0;
               idx_d   = '0;
               en_d    = 1'b1;
               rs_d    = 1'b0;
               data_d  = 8'h80;
            end
         end
         S_FRAME: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == EN_OFF) en_d = 1'b0;
            if (cnt_q == WR_END) begin
               cnt_d = '0;
               if (idx_q == LAST_WR) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d  = idx_q + 6'd1;
                  en_d   = 1'b1;
                  rs_d   = nxt_w[8];
                  data_d = nxt_w[7:0];
               end
            end
         end
         default: begin
            if (upd_valid) begin
               state_d  = S_CONVERT;
               cnt_d    = '0;
               opc_d    = opcode;
               est_nz_d = |estado;
               neg_d    = load_neg;
               shift_d  = load_mag;
               bcd_d    = '0;
            end
         end
      endcase
   end

   // State and datapath registers; reset clears the bus immediately and restarts power-up
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_PWRUP;
         cnt_q    <= '0;
         idx_q    <= '0;
         en_q     <= 1'b0;
         rs_q     <= 1'b0;
         data_q   <= 8'h00;
         opc_q    <= '0;
         est_nz_q <= 1'b0;
         neg_q    <= 1'b0;
         shift_q  <= '0;
         bcd_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         en_q     <= en_d;
         rs_q     <= rs_d;
         data_q   <= data_d;
         opc_q    <= opc_d;
         est_nz_q <= est_nz_d;
         neg_q    <= neg_d;
         shift_q  <= shift_d;
         bcd_q    <= bcd_d;
      end
   end

   assign upd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign lcd_en    = en_q;
   assign lcd_rs    = rs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// tb/tb_lcd_frame_ctrl.sv - scoreboard bench for lcd_frame_ctrl, signed and unsigned instances
module tb_lcd_frame_ctrl;

   localparam int STEP = 4;
   localparam int CLR  = 8;
   localparam int PWR  = 16;
   localparam int VW   = 16;
   localparam int DG   = 5;

   typedef struct {
      logic [8:0] w;
      int         gap;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        a_valid, a_ready, a_busy, a_en, a_rs, a_rw;
   logic [15:0] a_value;
   logic [2:0]  a_opcode, a_estado;
   logic [7:0]  a_data;

   logic        b_valid, b_ready, b_busy, b_en, b_rs, b_rw;
   logic [15:0] b_value;
   logic [2:0]  b_opcode, b_estado;
   logic [7:0]  b_data;

   int          n_vec, n_bad, cyc, acc_a, acc_b;
   wr_t         exp_a[$];
   wr_t         exp_b[$];
   logic        prev_en[2];
   logic [8:0]  prev_w[2];
   int          last_rise[2];
   int          hi_cnt[2];

   always #5 clk = ~clk;

   lcd_frame_ctrl #(
      .VALUE_W(VW), .DIGITS(DG), .SIGNED_MODE(1),
      .STEP_CYCLES(STEP), .CLEAR_CYCLES(CLR), .POWERUP_CYCLES(PWR)
   ) u_signed (
      .clk(clk), .rst_n(rst_n), .upd_valid(a_valid), .upd_ready(a_ready),
      .value(a_value), .opcode(a_opcode), .estado(a_estado), .busy(a_busy),
      .lcd_en(a_en), .lcd_rs(a_rs), .lcd_rw(a_rw), .lcd_data(a_data)
   );

   lcd_frame_ctrl #(
      .VALUE_W(VW), .DIGITS(DG), .SIGNED_MODE(0),
      .STEP_CYCLES(STEP), .CLEAR_CYCLES(CLR), .POWERUP_CYCLES(PWR)
   ) u_unsigned (
      .clk(clk), .rst_n(rst_n), .upd_valid(b_valid), .upd_ready(b_ready),
      .value(b_value), .opcode(b_opcode), .estado(b_estado), .busy(b_busy),
      .lcd_en(b_en), .lcd_rs(b_rs), .lcd_rw(b_rw), .lcd_data(b_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push(input int d, input logic [8:0] w, input int gap);
      wr_t e;
      e.w   = w;
      e.gap = gap;
      if (d == 0) exp_a.push_back(e);
      else        exp_b.push_back(e);
   endtask

   task automatic push_init(input int d);
      push(d, 9'h038, 0);
      push(d, 9'h00E, 2*STEP);
      push(d, 9'h001, 2*STEP);
      push(d, 9'h006, 2*STEP + CLR);
   endtask

   task automatic push_frame(input int d, input logic [15:0] v, input logic [2:0] op,
                             input logic [2:0] est, input bit sgn, input int gap0);
      string mn[8];
      string l1, l2, sc;
      int    mag;
      bit    neg;
      mn  = '{"LOAD", "ADD ", "ADDI", "SUB ", "SUBI", "MUL ", "CLR ", "DPL "};
      neg = sgn && v[15];
      mag = neg ? (65536 - int'(v)) : int'(v);
      if (est == 3'd0) l1 = "----       [---]";
      else             l1 = $sformatf("%s       [%b]", mn[op], op);
      if (!sgn)                       sc = " ";
      else if (est == 3'd0 || !neg)   sc = "+";
      else                            sc = "-";
      l2 = $sformatf("          %s%05d", sc, mag);
      push(d, 9'h080, gap0);
      for (int i = 0; i < 16; i++) push(d, {1'b1, l1[i]}, 2*STEP);
      push(d, 9'h0C0, 2*STEP);
      for (int i = 0; i < 16; i++) push(d, {1'b1, l2[i]}, 2*STEP);
   endtask

   task automatic mon(input int d, input logic en, input logic rs, input logic rw,
                      input logic [7:0] data);
      logic       rise;
      logic [8:0] w;
      wr_t        e;
      bit         have;
      w = {rs, data};
      if (!rst_n) begin
         prev_en[d]   = 1'b0;
         prev_w[d]    = 9'h000;
         last_rise[d] = -1;
         hi_cnt[d]    = 0;
         return;
      end
      rise = en && !prev_en[d];
      if (w !== prev_w[d]) chk($sformatf("dut%0d_bus_changes_only_on_en_rise", d), 32'(rise), 32'd1);
      if (rise) begin
         have = 1'b0;
         if (d == 0 && exp_a.size() > 0) begin e = exp_a.pop_front(); have = 1'b1; end
         if (d == 1 && exp_b.size() > 0) begin e = exp_b.pop_front(); have = 1'b1; end
         chk($sformatf("dut%0d_write_expected_c%0d", d, cyc), 32'(have), 32'd1);
         if (have) begin
            chk($sformatf("dut%0d_write_c%0d", d, cyc), 32'(w), 32'(e.w));
            if (e.gap != 0 && last_rise[d] >= 0)
               chk($sformatf("dut%0d_write_spacing_c%0d", d, cyc), 32'(cyc - last_rise[d]), 32'(e.gap));
         end
         chk($sformatf("dut%0d_rw_low", d), 32'(rw), 32'd0);
         last_rise[d] = cyc;
         hi_cnt[d]    = 1;
      end else if (en) begin
         hi_cnt[d]++;
      end
      if (!en && prev_en[d]) chk($sformatf("dut%0d_en_high_width_c%0d", d, cyc), 32'(hi_cnt[d]), 32'(STEP));
      prev_en[d] = en;
      prev_w[d]  = w;
   endtask

   task automatic tick();
      if (a_valid && a_ready) acc_a++;
      if (b_valid && b_ready) acc_b++;
      @(negedge clk);
      cyc++;
      mon(0, a_en, a_rs, a_rw, a_data);
      mon(1, b_en, b_rs, b_rw, b_data);
   endtask

   task automatic wait_ready(input int d, input int bound, output int k);
      k = 0;
      while (((d == 0) ? !a_ready : !b_ready) && k < bound) begin
         tick();
         k++;
      end
      chk($sformatf("dut%0d_ready_within_bound", d), 32'((d == 0) ? a_ready : b_ready), 32'd1);
   endtask

   task automatic accept_a(input logic [15:0] v, input logic [2:0] op, input logic [2:0] est,
                           output int first_en, output int k);
      a_value  = v;
      a_opcode = op;
      a_estado = est;
      a_valid  = 1'b1;
      push_frame(0, v, op, est, 1'b1, 0);
      tick();
      a_valid  = 1'b0;
      a_value  = ~v;
      a_opcode = ~op;
      a_estado = 3'd0;
      chk("accept_ready_drops", 32'(a_ready), 32'd0);
      chk("accept_busy_rises", 32'(a_busy), 32'd1);
      k        = 1;
      first_en = 0;
      while (!a_ready && k < 400) begin
         if (a_en && first_en == 0) first_en = k;
         tick();
         k++;
      end
      chk("accept_frame_done", 32'(a_ready), 32'd1);
   endtask

   task automatic power_up_check();
      int k;
      push_init(0);
      push_frame(0, 16'h0000, 3'd0, 3'd0, 1'b1, 2*STEP + VW);
      push_init(1);
      push_frame(1, 16'h0000, 3'd0, 3'd0, 1'b0, 2*STEP + VW);
      k = 0;
      while (!a_en && k < 100) begin
         tick();
         k++;
      end
      chk("first_en_after_powerup", 32'(k), 32'(PWR));
      wait_ready(0, 2000, k);
      wait_ready(1, 50, k);
      chk("init_queue_a_drained", 32'(exp_a.size()), 32'd0);
      chk("init_queue_b_drained", 32'(exp_b.size()), 32'd0);
      chk("idle_busy_low", 32'(a_busy), 32'd0);
   endtask

   initial begin
      int k, fe, acc0;
      n_vec = 0; n_bad = 0; cyc = 0; acc_a = 0; acc_b = 0;
      for (int d = 0; d < 2; d++) begin
         prev_en[d] = 1'b0; prev_w[d] = 9'h000; last_rise[d] = -1; hi_cnt[d] = 0;
      end
      a_valid = 1'b0; a_value = 16'h0; a_opcode = 3'd0; a_estado = 3'd0;
      b_valid = 1'b0; b_value = 16'h0; b_opcode = 3'd0; b_estado = 3'd0;
      rst_n   = 1'b0;
      #1;
      chk("rst_en", 32'(a_en), 32'd0);
      chk("rst_rs", 32'(a_rs), 32'd0);
      chk("rst_rw", 32'(a_rw), 32'd0);
      chk("rst_data", 32'(a_data), 32'h00);
      chk("rst_ready", 32'(a_ready), 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd1);
      chk("rst_b_en", 32'(b_en), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      power_up_check();

      accept_a(16'hFFFF, 3'b010, 3'd1, fe, k);
      chk("minus1_first_en", 32'(fe), 32'(VW + 1));
      chk("minus1_ready_latency", 32'(k), 32'(VW + 1 + 68*STEP));
      chk("minus1_queue_drained", 32'(exp_a.size()), 32'd0);

      accept_a(16'h8000, 3'b101, 3'd1, fe, k);
      chk("min_neg_ready_latency", 32'(k), 32'(VW + 1 + 68*STEP));
      chk("min_neg_queue_drained", 32'(exp_a.size()), 32'd0);

      acc0     = acc_a;
      a_value  = 16'h0005;
      a_opcode = 3'd0;
      a_estado = 3'd2;
      a_valid  = 1'b1;
      push_frame(0, 16'h0005, 3'd0, 3'd2, 1'b1, 0);
      for (int i = 0; i < 100; i++) tick();
      a_value  = 16'h7FFF;
      a_opcode = 3'd7;
      a_estado = 3'd3;
      push_frame(0, 16'h7FFF, 3'd7, 3'd3, 1'b1, 0);
      wait_ready(0, 400, k);
      tick();
      a_valid = 1'b0;
      chk("hold_ready_one_cycle", 32'(a_ready), 32'd0);
      chk("hold_accept_count", 32'(acc_a - acc0), 32'd2);
      wait_ready(0, 400, k);
      chk("hold_queue_drained", 32'(exp_a.size()), 32'd0);

      b_value  = 16'hFFFF;
      b_opcode = 3'd0;
      b_estado = 3'd1;
      b_valid  = 1'b1;
      push_frame(1, 16'hFFFF, 3'd0, 3'd1, 1'b0, 0);
      tick();
      b_valid = 1'b0;
      chk("unsigned_ready_drops", 32'(b_ready), 32'd0);
      wait_ready(1, 400, k);
      chk("unsigned_queue_drained", 32'(exp_b.size()), 32'd0);

      a_value  = 16'h0042;
      a_opcode = 3'd1;
      a_estado = 3'd1;
      a_valid  = 1'b1;
      push_frame(0, 16'h0042, 3'd1, 3'd1, 1'b1, 0);
      tick();
      a_valid = 1'b0;
      k = 0;
      while (exp_a.size() > 8 && k < 400) begin
         tick();
         k++;
      end
      chk("reached_line2_before_reset", 32'(exp_a.size() <= 8), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midframe_rst_en", 32'(a_en), 32'd0);
      chk("midframe_rst_data", 32'(a_data), 32'h00);
      chk("midframe_rst_rs", 32'(a_rs), 32'd0);
      chk("midframe_rst_ready", 32'(a_ready), 32'd0);
      chk("midframe_rst_busy", 32'(a_busy), 32'd1);
      exp_a.delete();
      exp_b.delete();
      tick();
      tick();
      rst_n = 1'b1;
      power_up_check();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
